// File: rtl/xor_descrambler.sv
// ---------------------------------------------------------------------------
// xor_descrambler
// Serial-in, word-out descrambler. Each accepted serial bit is XORed with the
// low bit of an 8-bit Fibonacci LFSR (descramble mode) or passed through
// unchanged (pass-through mode). Eight bits form a word, which is held in an
// output register behind a valid/ready handshake. A word that completes
// while the output register still holds an undelivered word is dropped, and
// a sticky overflow flag is set.
// ---------------------------------------------------------------------------
module xor_descrambler (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start_i,
  input  logic       E_i,
  input  logic       valid_i,
  input  logic       sel_i,
  input  logic       data_ready_i,
  output logic [7:0] data_o,
  output logic       data_valid_o,
  output logic       busy_o,
  output logic       overflow_o
);

  localparam logic [7:0] LFSR_SEED = 8'hA5;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Control state
  state_e     state_q;
  logic       busy_q;

  // Bit-level datapath state
  logic [7:0] lfsr_q,  lfsr_d;
  logic [2:0] cnt_q,   cnt_d;
  logic       mode_q,  mode_d;
  logic [7:0] shreg_q, shreg_d;

  // Output register state
  logic [7:0] data_q,  data_d;
  logic       valid_q, valid_d;
  logic       ovf_q,   ovf_d;

  // Per-cycle decode signals
  logic       accept;
  logic       mode_eff;
  logic       dec_bit;
  logic       word_done;
  logic       xfer;
  logic [7:0] word_full;

  // One LFSR step: feedback from taps 0,2,3,4 enters at the top, shift right.
  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[4], l[7:1]};
  endfunction

  // FSM: IDLE until the first start, then SHIFT forever (start restarts).
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: sequential state always uses non-blocking (<=) so every register
    // samples the pre-edge values of the others, independent of block order.
    if (!reset_n) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
    end else if (start_i) begin
      state_q <= ST_SHIFT;
      busy_q  <= 1'b1;
    end
  end

  // A bit is taken only in SHIFT with valid data and no start this cycle;
  // the mode is latched on the first bit of a word and held for the rest.
  always_comb begin
    accept    = (state_q == ST_SHIFT) && valid_i && !start_i;
    mode_eff  = (cnt_q == 3'd0) ? sel_i : mode_q;
    dec_bit   = mode_eff ? E_i : (E_i ^ lfsr_q[0]);
    word_done = accept && (cnt_q == 3'd7);
    xfer      = valid_q && data_ready_i;
  end

  // The eighth bit goes straight into bit 7 of the finished word, so the
  // word is available in the same cycle it completes.
  always_comb begin
    word_full    = shreg_q;
    word_full[7] = dec_bit;
  end

  // Next state of the LFSR, bit counter, held mode and partial word.
  always_comb begin
    // NOTE: every next-state signal gets its hold value first so that no
    // branch leaves it unassigned; otherwise synthesis infers a latch.
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    shreg_d = shreg_q;
    if (start_i) begin
      lfsr_d  = LFSR_SEED;
      cnt_d   = 3'd0;
      shreg_d = 8'h00;
    end else if (accept) begin
      lfsr_d = lfsr_step(lfsr_q);
      cnt_d  = cnt_q + 3'd1;  // wraps 7 -> 0 on the word-completing bit
      mode_d = mode_eff;
      if (word_done) begin
        shreg_d = 8'h00;
      end else begin
        shreg_d[cnt_q] = dec_bit;
      end
    end
  end

  // Next state of the output register, valid flag and sticky overflow.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    if (start_i) begin
      ovf_d = 1'b0;
    end
    if (word_done) begin
      if (!valid_q || data_ready_i) begin
        // Register empty, or being emptied this very cycle: load new word.
        data_d  = word_full;
        valid_d = 1'b1;
      end else begin
        // Undelivered word still waiting: keep it, drop the new one.
        ovf_d = 1'b1;
      end
    end else if (xfer) begin
      valid_d = 1'b0;
    end
  end

  // Bit-level datapath registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_q  <= LFSR_SEED;
      cnt_q   <= 3'd0;
      mode_q  <= 1'b0;
      shreg_q <= 8'h00;
    end else begin
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      shreg_q <= shreg_d;
    end
  end

  // Output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign data_o       = data_q;
  assign data_valid_o = valid_q;
  assign busy_o       = busy_q;
  assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_xor_descrambler.sv
// ---------------------------------------------------------------------------
// tb_xor_descrambler
// Scenario tasks drive the descrambler and compare its outputs against a
// behavioural model that tracks the key stream and word delivery directly.
// ---------------------------------------------------------------------------
module tb_xor_descrambler;

  logic       clock;
  logic       reset_n;
  logic       start_i;
  logic       E_i;
  logic       valid_i;
  logic       sel_i;
  logic       data_ready_i;
  logic [7:0] data_o;
  logic       data_valid_o;
  logic       busy_o;
  logic       overflow_o;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  bit         m_busy;
  bit [7:0]   m_key;
  int         m_cnt;
  bit         m_mode;
  bit         m_bits[8];
  bit [7:0]   m_data;
  bit         m_valid;
  bit         m_ovf;

  xor_descrambler dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .start_i      (start_i),
    .E_i          (E_i),
    .valid_i      (valid_i),
    .sel_i        (sel_i),
    .data_ready_i (data_ready_i),
    .data_o       (data_o),
    .data_valid_o (data_valid_o),
    .busy_o       (busy_o),
    .overflow_o   (overflow_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic bit [7:0] key_advance(input bit [7:0] l);
    bit fb;
    fb = l[0] ^ l[2] ^ l[3] ^ l[4];
    return {fb, l[7:1]};
  endfunction

  task automatic model_reset();
    m_busy  = 0;
    m_key   = 8'hA5;
    m_cnt   = 0;
    m_mode  = 0;
    foreach (m_bits[i]) m_bits[i] = 0;
    m_data  = 8'h00;
    m_valid = 0;
    m_ovf   = 0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit       xfer;
    bit       done;
    bit       b;
    bit [7:0] word;
    xfer = m_valid && data_ready_i;
    done = 0;
    if (start_i) begin
      m_busy = 1;
      m_key  = 8'hA5;
      m_cnt  = 0;
      m_ovf  = 0;
      foreach (m_bits[i]) m_bits[i] = 0;
    end else if (m_busy && valid_i) begin
      if (m_cnt == 0) m_mode = sel_i;
      b = m_mode ? E_i : (E_i ^ m_key[0]);
      m_bits[m_cnt] = b;
      m_key = key_advance(m_key);
      m_cnt++;
      if (m_cnt == 8) begin
        for (int i = 0; i < 8; i++) word[i] = m_bits[i];
        m_cnt = 0;
        done  = 1;
        if (!m_valid || data_ready_i) begin
          m_data  = word;
          m_valid = 1;
        end else begin
          m_ovf = 1;
        end
      end
    end
    if (!done && xfer) m_valid = 0;
  endtask

  // One clock: update the model, take the edge, settle 1 time unit after.
  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    start_i      = 0;
    E_i          = 0;
    valid_i      = 0;
    sel_i        = 0;
    data_ready_i = 0;
  endtask

  task automatic do_start();
    idle_inputs();
    start_i = 1;
    tick();
    start_i = 0;
  endtask

  // Send one word LSB first, all bits valid, constant sel/ready.
  task automatic send_word(input bit [7:0] w, input bit sel, input bit rdy);
    for (int i = 0; i < 8; i++) begin
      valid_i      = 1;
      E_i          = w[i];
      sel_i        = sel;
      data_ready_i = rdy;
      tick();
    end
    valid_i      = 0;
    data_ready_i = 0;
  endtask

  task automatic drain();
    idle_inputs();
    data_ready_i = 1;
    tick();
    data_ready_i = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1;
    n_checks++;
    if ({data_o, data_valid_o, busy_o, overflow_o} !== 11'h000)
      $display("FAIL reset_state: got data=%h valid=%b busy=%b ovf=%b, want all zero",
               data_o, data_valid_o, busy_o, overflow_o);
    else n_pass++;
    // Bits before any start are ignored.
    send_word(8'hFF, 1'b1, 1'b0);
    n_checks++;
    if (data_valid_o !== 1'b0 || busy_o !== 1'b0)
      $display("FAIL idle_ignores_bits: valid=%b busy=%b, want 0 0", data_valid_o, busy_o);
    else n_pass++;
  endtask

  task automatic test_seed_word();
    do_start();
    n_checks++;
    if (busy_o !== 1'b1) $display("FAIL busy_after_start: got %b want 1", busy_o);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      valid_i = 1;
      E_i     = 1'(8'hA5 >> i);
      sel_i   = 0;
      tick();
      if (i == 6) begin
        n_checks++;
        if (data_valid_o !== 1'b0) $display("FAIL valid_before_8th: got %b want 0", data_valid_o);
        else n_pass++;
      end
    end
    valid_i = 0;
    n_checks++;
    if (data_valid_o !== 1'b1 || data_o !== 8'h00)
      $display("FAIL seed_word: got valid=%b data=%h want 1 00", data_valid_o, data_o);
    else n_pass++;
  endtask

  task automatic test_mode_switch();
    drain();
    do_start();
    send_word(8'h5A, 1'b0, 1'b0);
    n_checks++;
    if (data_o !== 8'hFF || data_valid_o !== 1'b1)
      $display("FAIL descramble_5a: got data=%h valid=%b want ff 1", data_o, data_valid_o);
    else n_pass++;
    drain();
    n_checks++;
    if (data_valid_o !== 1'b0) $display("FAIL ready_clears_valid: got %b want 0", data_valid_o);
    else n_pass++;
    // Pass-through word; sel_i drops after the first bit and must be ignored.
    for (int i = 0; i < 8; i++) begin
      valid_i = 1;
      E_i     = 1'(8'h3C >> i);
      sel_i   = (i == 0);
      tick();
    end
    valid_i = 0;
    n_checks++;
    if (data_o !== 8'h3C || data_valid_o !== 1'b1)
      $display("FAIL passthrough_3c: got data=%h valid=%b want 3c 1", data_o, data_valid_o);
    else n_pass++;
    // The key kept advancing through the pass-through word.
    send_word(8'h00, 1'b0, 1'b1);
    n_checks++;
    if (data_o !== m_data) $display("FAIL key_after_passthru: got %h want %h", data_o, m_data);
    else n_pass++;
  endtask

  task automatic test_overflow();
    drain();
    do_start();
    send_word(8'h12, 1'b1, 1'b0);
    send_word(8'h34, 1'b1, 1'b0);
    n_checks++;
    if (data_o !== 8'h12 || data_valid_o !== 1'b1 || overflow_o !== 1'b1)
      $display("FAIL overflow_drop: got data=%h valid=%b ovf=%b want 12 1 1",
               data_o, data_valid_o, overflow_o);
    else n_pass++;
    do_start();
    n_checks++;
    if (overflow_o !== 1'b0 || data_valid_o !== 1'b1 || data_o !== 8'h12)
      $display("FAIL start_clears_ovf: got ovf=%b valid=%b data=%h want 0 1 12",
               overflow_o, data_valid_o, data_o);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    drain();
    do_start();
    send_word(8'hC3, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      valid_i      = 1;
      E_i          = 1'(8'h69 >> i);
      sel_i        = 1;
      data_ready_i = (i == 7);
      tick();
    end
    idle_inputs();
    n_checks++;
    if (data_valid_o !== 1'b1 || data_o !== 8'h69 || overflow_o !== 1'b0)
      $display("FAIL back_to_back: got valid=%b data=%h ovf=%b want 1 69 0",
               data_valid_o, data_o, overflow_o);
    else n_pass++;
  endtask

  task automatic test_reset_midword();
    drain();
    do_start();
    for (int i = 0; i < 4; i++) begin
      valid_i = 1;
      E_i     = i[0];
      tick();
    end
    idle_inputs();
    send_word(8'h0F, 1'b1, 1'b0);  // leaves a valid word in the output register
    #2;
    reset_n = 0;
    #1;
    model_reset();
    n_checks++;
    if ({data_o, data_valid_o, busy_o, overflow_o} !== 11'h000)
      $display("FAIL async_reset: got data=%h valid=%b busy=%b ovf=%b want all zero",
               data_o, data_valid_o, busy_o, overflow_o);
    else n_pass++;
    @(posedge clock);
    #1;
    reset_n = 1;
    send_word(8'hA5, 1'b0, 1'b0);
    n_checks++;
    if (data_valid_o !== 1'b0)
      $display("FAIL no_word_without_start: got valid=%b want 0", data_valid_o);
    else n_pass++;
    do_start();
    send_word(8'hA5, 1'b0, 1'b0);
    n_checks++;
    if (data_o !== 8'h00 || data_valid_o !== 1'b1)
      $display("FAIL reset_then_seed: got data=%h valid=%b want 00 1", data_o, data_valid_o);
    else n_pass++;
  endtask

  task automatic test_gaps();
    bit [7:0] w;
    int       sent;
    int       guard;
    drain();
    w = 8'($urandom);
    // Start together with a valid bit: that bit must be dropped.
    start_i = 1;
    valid_i = 1;
    E_i     = ~w[0];
    tick();
    start_i = 0;
    sent    = 0;
    guard   = 0;
    while (sent < 8 && guard < 200) begin
      valid_i = ($urandom_range(0, 2) != 0);
      E_i     = valid_i ? w[sent] : 1'($urandom);
      sel_i   = (sent == 0) ? 1'b0 : 1'($urandom);
      tick();
      if (valid_i) sent++;
      guard++;
    end
    idle_inputs();
    n_checks++;
    if (data_valid_o !== 1'b1 || data_o !== (w ^ 8'hA5))
      $display("FAIL gapped_word: got valid=%b data=%h want 1 %h", data_valid_o, data_o, w ^ 8'hA5);
    else n_pass++;
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    drain();
    for (int c = 0; c < 600; c++) begin
      start_i      = ($urandom_range(0, 59) == 0);
      valid_i      = ($urandom_range(0, 9) < 7);
      E_i          = 1'($urandom);
      sel_i        = 1'($urandom);
      data_ready_i = ($urandom_range(0, 9) < 3);
      tick();
      n_checks++;
      if ({data_o, data_valid_o, overflow_o, busy_o} !== {m_data, m_valid, m_ovf, m_busy}) begin
        if (errs < 10)
          $display("FAIL random_cycle_%0d: got data=%h v=%b ovf=%b busy=%b want %h %b %b %b",
                   c, data_o, data_valid_o, overflow_o, busy_o, m_data, m_valid, m_ovf, m_busy);
        errs++;
      end else n_pass++;
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset_n = 1;
    model_reset();
    test_reset();
    test_seed_word();
    test_mode_switch();
    test_overflow();
    test_back_to_back();
    test_reset_midword();
    test_gaps();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
